timer_unit: RTL and testbench
=============================

Name: timer_unit

Overview:
- Memory-less timer peripheral sitting beside the register file.
- Consumes the 32-bit timer-control word (contents of the TCON register) and produces the 16-bit counter value that software reads back through the TMR register address.
- Adds a prescaler, compare/auto-reload and one-shot modes, plus a one-cycle event pulse for polling or future interrupt logic.

Parameters:
CNT_W, 16, counter width; must match the tmr_cntr width the register file expects.
PRESC_W, 8, prescaler field width in the control word.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset.
tmr_ctrl  input  32  control word from register file (TCON contents).
tmr_cntr  output  CNT_W  current counter value, to register file TMR read path.
tmr_evt  output  1  one-cycle pulse on terminal count.
tmr_busy  output  1  high while in RUN state.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- tmr_ctrl fields:
  - [0] EN
  - [1] MODE: 0 = free-run wrap at 16'hFFFF; 1 = compare/reload at CMP.
  - [2] CLR, level-sensitive.
  - [3] ONESHOT.
  - [7:4] reserved; ignored.
  - [15:8] PRESC: tick every PRESC+1 clocks.
  - [31:16] CMP.
- Timing: the register file writes TCON on negedge, so tmr_ctrl is stable at posedge. Sample it directly; no extra synchroniser.
- Reset (rst_n=0 at posedge): tmr_cntr=0, presc_cnt=0, state=IDLE, tmr_evt=0, tmr_busy=0.
- FSM states IDLE, RUN, HALT. Priority each cycle: reset > CLR > state logic.
- CLR=1, any state: tmr_cntr<=0, presc_cnt<=0, state<=IDLE, tmr_evt<=0. Overrides EN.
- IDLE:
  - tmr_cntr holds, so pausing and resuming preserves the count.
  - EN=1 -> RUN. The first presc_cnt increment happens on the following posedge.
- RUN:
  - EN=0 -> IDLE; presc_cnt<=0; tmr_cntr holds.
  - Otherwise presc_cnt increments each cycle.
  - Tick: when presc_cnt >= PRESC, presc_cnt<=0. Use >=, not ==, so lowering PRESC mid-count ticks on the next cycle.
- On a tick, terminal condition:
  - MODE=0: tmr_cntr==all-ones.
  - MODE=1: tmr_cntr>=CMP. Use >=, so lowering CMP below the current count fires on the next tick.
  - Terminal: tmr_cntr<=0 and tmr_evt<=1 for exactly one cycle. If ONESHOT=1, state<=HALT.
  - Non-terminal: tmr_cntr<=tmr_cntr+1, wrapping modulo 2^CNT_W.
- tmr_evt is registered: high in the cycle after the terminal tick edge, otherwise 0.
- HALT:
  - tmr_cntr holds 0; no ticks; tmr_busy=0.
  - EN=0 -> IDLE. EN remaining 1 stays in HALT (software must drop EN to re-arm).
- Edge cases:
  - PRESC=0: tick every cycle.
  - MODE=1, CMP=0: every tick is terminal; tmr_cntr stays 0 and tmr_evt pulses once per tick.
  - MODE or ONESHOT changes in RUN take effect at the next tick; no state reset.
- Mid-operation reset: any state returns to reset values at that posedge; no pending event survives.
- tmr_busy = (state==RUN), registered with the state.

Decomposition:
- Shared header include/timer.v holds:
  - field bit positions/ranges for EN, MODE, CLR, ONESHOT, PRESC, CMP;
  - state encodings IDLE=2'd0, RUN=2'd1, HALT=2'd2.
- This header sits alongside the existing register-address defines.
- One sub-module is natural: timer_presc. It holds the prescaler counter and produces the tick; inputs clk, rst_n, clr, run, presc.
- Top level holds the FSM, counter and compare logic.

Test Plan:
- Reset with tmr_ctrl=0, then set EN=1, PRESC=0, MODE=0 -> tmr_cntr counts 1,2,3... one per cycle from the second posedge after EN; tmr_busy=1.
- EN=1, PRESC=3, MODE=1, CMP=5 -> count advances every 4 cycles 0..5; tmr_evt pulses one cycle; count returns to 0; period 24 cycles.
- Same setup plus ONESHOT=1 -> single tmr_evt; state HALT; tmr_cntr stays 0 and tmr_busy=0 for 100 cycles; EN=0 then EN=1 re-arms.
- Free-run, PRESC=0, preload by running to 16'hFFFE -> next ticks give FFFF then 0 with one tmr_evt.
- In RUN at count 7, assert CLR with EN=1 -> next posedge tmr_cntr=0, IDLE, no tmr_evt; drop CLR -> RUN resumes.
- In RUN at count 9 with CMP=20, write CMP=4 -> the next tick is terminal: tmr_evt=1, tmr_cntr=0. Then, mid-count, rst_n=0 for one posedge -> all outputs 0.

Source files
------------

// File: rtl/timer_unit_pkg.sv
// Shared definitions for the timer peripheral: TCON field positions and FSM encodings.
package timer_unit_pkg;

  localparam int EN_BIT      = 0;
  localparam int MODE_BIT    = 1;
  localparam int CLR_BIT     = 2;
  localparam int ONESHOT_BIT = 3;
  localparam int RSVD_LSB    = 4;
  localparam int RSVD_MSB    = 7;
  localparam int PRESC_LSB   = 8;
  localparam int PRESC_MSB   = 15;
  localparam int CMP_LSB     = 16;
  localparam int CMP_MSB     = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/timer_unit_if.sv
// Control word in, counter/event/busy back out, between the register file and the timer.
interface timer_unit_if #(parameter int CNT_W = 16);
  logic [31:0]    tmr_ctrl;
  logic [CNT_W-1:0] tmr_cntr;
  logic           tmr_evt;
  logic           tmr_busy;

  modport master (output tmr_ctrl, input tmr_cntr, input tmr_evt, input tmr_busy);
  modport slave  (input tmr_ctrl, output tmr_cntr, output tmr_evt, output tmr_busy);
endinterface

// File: rtl/timer_unit_presc.sv
// Prescaler: counts clocks while running and ticks once every presc+1 clocks.
module timer_unit_presc #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] r_presc_cnt;

  // >= so a lowered prescale value ticks on the very next cycle
  assign tick = run && (r_presc_cnt >= presc);

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !run || tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_unit.sv
// Timer peripheral: FSM, counter and compare logic around the prescaler.
module timer_unit
  import timer_unit_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  timer_unit_if.slave bus
);

  logic               w_en;
  logic               w_mode;
  logic               w_clr;
  logic               w_oneshot;
  logic [PRESC_W-1:0] w_presc;
  logic [CNT_W-1:0]   w_cmp;
  logic               w_unused_rsvd;
  logic               w_run;
  logic               w_tick;
  logic               w_terminal;

  tmr_state_e       r_state;
  tmr_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cntr;
  logic [CNT_W-1:0] w_cntr_nxt;
  logic             r_evt;
  logic             w_evt_nxt;
  logic             r_busy;

  assign w_en          = bus.tmr_ctrl[EN_BIT];
  assign w_mode        = bus.tmr_ctrl[MODE_BIT];
  assign w_clr         = bus.tmr_ctrl[CLR_BIT];
  assign w_oneshot     = bus.tmr_ctrl[ONESHOT_BIT];
  assign w_presc       = bus.tmr_ctrl[PRESC_LSB +: PRESC_W];
  assign w_cmp         = bus.tmr_ctrl[CMP_LSB +: CNT_W];
  assign w_unused_rsvd = ^bus.tmr_ctrl[RSVD_MSB:RSVD_LSB];

  // Prescaler only advances in RUN with EN held and no clear pending
  assign w_run = (r_state == ST_RUN) && w_en && !w_clr;

  timer_unit_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .run   (w_run),
    .presc (w_presc),
    .tick  (w_tick)
  );

  assign w_terminal = w_mode ? (r_cntr >= w_cmp) : (r_cntr == {CNT_W{1'b1}});

  always_comb begin
    w_state_nxt = r_state;
    w_cntr_nxt  = r_cntr;
    w_evt_nxt   = 1'b0;
    if (w_clr) begin
      w_state_nxt = ST_IDLE;
      w_cntr_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!w_en) begin
            w_state_nxt = ST_IDLE;
          end else if (w_tick) begin
            if (w_terminal) begin
              w_cntr_nxt = '0;
              w_evt_nxt  = 1'b1;
              if (w_oneshot) w_state_nxt = ST_HALT;
            end else begin
              w_cntr_nxt = r_cntr + 1'b1;
            end
          end
        end
        ST_HALT: begin
          w_cntr_nxt = '0;
          if (!w_en) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cntr_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cntr  <= '0;
      r_evt   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cntr  <= w_cntr_nxt;
      r_evt   <= w_evt_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
    end
  end

  assign bus.tmr_cntr = r_cntr;
  assign bus.tmr_evt  = r_evt;
  assign bus.tmr_busy = r_busy;

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: vector table plus multi-cycle corner sequences.
module tb_timer_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  timer_unit_if #(.CNT_W(16)) bus ();

  timer_unit #(.CNT_W(16), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ctrl;
    int          ncyc;
    logic [15:0] cntr;
    logic        evt;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk(bit en, bit mode, bit clr, bit os,
                                     logic [7:0] presc, logic [15:0] cmp);
    return {cmp, presc, 4'b0000, os, clr, mode, en};
  endfunction

  function automatic vec_t v(logic [31:0] ctrl, int ncyc, logic [15:0] cntr,
                             logic evt, logic busy);
    vec_t r;
    r.ctrl = ctrl; r.ncyc = ncyc; r.cntr = cntr; r.evt = evt; r.busy = busy;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [15:0] c, input logic e, input logic b);
    chk({name, ".cntr"}, 32'(bus.tmr_cntr), 32'(c));
    chk({name, ".evt"},  32'(bus.tmr_evt),  32'(e));
    chk({name, ".busy"}, 32'(bus.tmr_busy), 32'(b));
  endtask

  initial begin
    int evt_cnt, first_evt, second_evt, bad;

    rst_n = 1'b0;
    bus.tmr_ctrl = 32'h0;
    step(2);
    chk_out("reset", 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // run, pause, resume, clear, compare mode, CMP=0
    vecs.push_back(v(mk(1,0,0,0,8'd0,16'd0), 1, 16'd0, 0, 1));
    vecs.push_back(v(mk(1,0,0,0,8'd0,16'd0), 1, 16'd1, 0, 1));
    vecs.push_back(v(mk(1,0,0,0,8'd0,16'd0), 3, 16'd4, 0, 1));
    vecs.push_back(v(mk(0,0,0,0,8'd0,16'd0), 1, 16'd4, 0, 0));
    vecs.push_back(v(mk(0,0,0,0,8'd0,16'd0), 5, 16'd4, 0, 0));
    vecs.push_back(v(mk(1,0,0,0,8'd0,16'd0), 1, 16'd4, 0, 1));
    vecs.push_back(v(mk(1,0,0,0,8'd0,16'd0), 1, 16'd5, 0, 1));
    vecs.push_back(v(mk(1,0,1,0,8'd0,16'd0), 1, 16'd0, 0, 0));
    vecs.push_back(v(mk(1,0,1,0,8'd0,16'd0), 3, 16'd0, 0, 0));
    vecs.push_back(v(mk(1,1,0,0,8'd0,16'd2), 1, 16'd0, 0, 1));
    vecs.push_back(v(mk(1,1,0,0,8'd0,16'd2), 2, 16'd2, 0, 1));
    vecs.push_back(v(mk(1,1,0,0,8'd0,16'd2), 1, 16'd0, 1, 1));
    vecs.push_back(v(mk(1,1,0,0,8'd0,16'd2), 1, 16'd1, 0, 1));
    vecs.push_back(v(mk(1,1,0,0,8'd0,16'd0), 1, 16'd0, 1, 1));
    vecs.push_back(v(mk(1,1,0,0,8'd0,16'd0), 1, 16'd0, 1, 1));
    vecs.push_back(v(mk(0,0,1,0,8'd0,16'd0), 1, 16'd0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      bus.tmr_ctrl = vecs[i].ctrl;
      step(vecs[i].ncyc);
      chk_out($sformatf("vec%0d", i), vecs[i].cntr, vecs[i].evt, vecs[i].busy);
    end

    // prescale 3, compare 5: 24-cycle period
    bus.tmr_ctrl = mk(1,1,0,0,8'd3,16'd5);
    evt_cnt = 0; first_evt = -1; second_evt = -1;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      if (k == 13) chk("presc.cntr_k13", 32'(bus.tmr_cntr), 32'd3);
      if (k == 24) chk("presc.cntr_k24", 32'(bus.tmr_cntr), 32'd5);
      if (bus.tmr_evt) begin
        evt_cnt++;
        if (first_evt < 0) first_evt = k;
        else if (second_evt < 0) second_evt = k;
      end
    end
    chk("presc.first_evt", 32'(first_evt), 32'd25);
    chk("presc.second_evt", 32'(second_evt), 32'd49);
    chk("presc.evt_count", 32'(evt_cnt), 32'd2);

    // one-shot: single event, HALT holds, re-arm needs EN low
    bus.tmr_ctrl = mk(0,0,1,0,8'd0,16'd0);
    step(1);
    bus.tmr_ctrl = mk(1,1,0,1,8'd3,16'd5);
    step(24);
    chk_out("os.pre", 16'd5, 1'b0, 1'b1);
    step(1);
    chk_out("os.evt", 16'd0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (bus.tmr_cntr !== 16'd0 || bus.tmr_evt !== 1'b0 || bus.tmr_busy !== 1'b0) bad++;
    end
    chk("os.halt_hold", 32'(bad), 32'd0);
    bus.tmr_ctrl = mk(0,1,0,1,8'd3,16'd5);
    step(1);
    chk_out("os.idle", 16'd0, 1'b0, 1'b0);
    bus.tmr_ctrl = mk(1,1,0,1,8'd3,16'd5);
    step(1);
    chk_out("os.rearm", 16'd0, 1'b0, 1'b1);
    step(4);
    chk_out("os.rearm_tick", 16'd1, 1'b0, 1'b1);

    // CLR at count 7 with EN held
    bus.tmr_ctrl = mk(0,0,1,0,8'd0,16'd0);
    step(1);
    bus.tmr_ctrl = mk(1,0,0,0,8'd0,16'd0);
    step(8);
    chk_out("clr.at7", 16'd7, 1'b0, 1'b1);
    bus.tmr_ctrl = mk(1,0,1,0,8'd0,16'd0);
    step(1);
    chk_out("clr.cleared", 16'd0, 1'b0, 1'b0);
    bus.tmr_ctrl = mk(1,0,0,0,8'd0,16'd0);
    step(1);
    chk_out("clr.resume", 16'd0, 1'b0, 1'b1);
    step(1);
    chk_out("clr.count1", 16'd1, 1'b0, 1'b1);

    // lower CMP below count, then mid-count reset
    bus.tmr_ctrl = mk(0,0,1,0,8'd0,16'd0);
    step(1);
    bus.tmr_ctrl = mk(1,1,0,0,8'd0,16'd20);
    step(10);
    chk_out("cmp.at9", 16'd9, 1'b0, 1'b1);
    bus.tmr_ctrl = mk(1,1,0,0,8'd0,16'd4);
    step(1);
    chk_out("cmp.lowered", 16'd0, 1'b1, 1'b1);
    step(3);
    chk_out("cmp.recount", 16'd3, 1'b0, 1'b1);
    rst_n = 1'b0;
    step(1);
    chk_out("rst.mid", 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1);
    chk_out("rst.rerun", 16'd0, 1'b0, 1'b1);

    // free-run wrap past all-ones
    bus.tmr_ctrl = mk(0,0,1,0,8'd0,16'd0);
    step(1);
    bus.tmr_ctrl = mk(1,0,0,0,8'd0,16'd0);
    step(65535);
    chk_out("wrap.fffe", 16'hFFFE, 1'b0, 1'b1);
    step(1);
    chk_out("wrap.ffff", 16'hFFFF, 1'b0, 1'b1);
    step(1);
    chk_out("wrap.zero", 16'h0000, 1'b1, 1'b1);
    step(1);
    chk_out("wrap.one", 16'h0001, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
